conv1d_row_pe_sync: RTL and testbench

Clocked, parametrised successor to the asynchronous row-convolution PE. It holds one filter row and one ifmap row in local register files and computes a 1-D convolution with configurable filter length, ifmap length and stride. Each output psum can optionally be accumulated with an incoming psum from the upstream PE. It sits in a PE column: psum_in comes from the PE above and psum_out goes to the PE below.

---
 rtl/conv1d_row_pe_sync.sv | 184 ++++++++++++++++++
 tb/tb_conv1d_row_pe_sync.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_row_pe_sync.sv
// Row-convolution PE: local filter/ifmap register files, one MAC per cycle,
// optional accumulation of an upstream psum, valid/ready psum output.
module conv1d_row_pe_sync #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PSUM_WIDTH = 20,  // must be >= 2*WIDTH
  parameter int unsigned DEPTH_F    = 8,
  parameter int unsigned ADDR_F     = 3,
  parameter int unsigned DEPTH_I    = 16,
  parameter int unsigned ADDR_I     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  filter_wr_en,
  input  logic [ADDR_F-1:0]     filter_wr_addr,
  input  logic [WIDTH-1:0]      filter_wr_data,
  input  logic                  ifmap_wr_en,
  input  logic [ADDR_I-1:0]     ifmap_wr_addr,
  input  logic [WIDTH-1:0]      ifmap_wr_data,
  input  logic [ADDR_F:0]       cfg_filt_len,
  input  logic [ADDR_I:0]       cfg_ifmap_len,
  input  logic [ADDR_I-1:0]     cfg_stride,
  input  logic                  cfg_psum_en,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  input  logic                  psum_in_valid,
  output logic                  psum_in_ready,
  input  logic [PSUM_WIDTH-1:0] psum_in_data,
  output logic                  psum_out_valid,
  input  logic                  psum_out_ready,
  output logic [PSUM_WIDTH-1:0] psum_out_data
);

  typedef enum logic [2:0] {StIdle, StMac, StPsum, StEmit, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]      filt_q [DEPTH_F];
  logic [WIDTH-1:0]      ifm_q  [DEPTH_I];

  logic [ADDR_F:0]       flen_q;
  logic [ADDR_I:0]       ilen_q;
  logic [ADDR_I-1:0]     stride_q;
  logic                  psum_en_q;

  // base_q is k*S, the first ifmap index of the current output window
  logic [ADDR_I-1:0]     base_q, base_d;
  logic [ADDR_F-1:0]     j_q, j_d;
  logic [PSUM_WIDTH-1:0] acc_q, acc_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  cfg_ok;
  logic                  accept;
  logic                  last_tap;
  logic                  last_out;
  logic [ADDR_I-1:0]     ifm_idx;
  logic [2*WIDTH-1:0]    prod;

  assign cfg_ok = (cfg_filt_len != '0) &&
                  (32'(cfg_filt_len) <= DEPTH_F) &&
                  (32'(cfg_ifmap_len) <= DEPTH_I) &&
                  (32'(cfg_filt_len) <= 32'(cfg_ifmap_len)) &&
                  (cfg_stride != '0);
  assign accept = (state_q == StIdle) && start && cfg_ok;

  assign last_tap = (32'(j_q) + 32'd1) == 32'(flen_q);
  // Last output when the next window would run past the end of the ifmap
  assign last_out = (32'(base_q) + 32'(stride_q) + 32'(flen_q)) > 32'(ilen_q);

  assign ifm_idx = base_q + ADDR_I'(j_q);
  assign prod    = filt_q[j_q] * ifm_q[ifm_idx];
  assign busy    = (state_q != StIdle);
  assign cfg_err = cfg_err_q;

  // Register files: host writes only while idle, out-of-range addresses dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_F); i++) filt_q[i] <= '0;
      for (int i = 0; i < int'(DEPTH_I); i++) ifm_q[i] <= '0;
    end else if (!busy) begin
      if (filter_wr_en && (32'(filter_wr_addr) < DEPTH_F)) begin
        filt_q[filter_wr_addr] <= filter_wr_data;
      end
      if (ifmap_wr_en && (32'(ifmap_wr_addr) < DEPTH_I)) begin
        ifm_q[ifmap_wr_addr] <= ifmap_wr_data;
      end
    end
  end

  // Config snapshot taken on an accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      flen_q    <= '0;
      ilen_q    <= '0;
      stride_q  <= '0;
      psum_en_q <= 1'b0;
    end else if (accept) begin
      flen_q    <= cfg_filt_len;
      ilen_q    <= cfg_ifmap_len;
      stride_q  <= cfg_stride;
      psum_en_q <= cfg_psum_en;
    end
  end

  // State, counters and accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      base_q    <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      j_q       <= j_d;
      acc_q     <= acc_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    j_d            = j_q;
    acc_d          = acc_q;
    cfg_err_d      = 1'b0;
    psum_in_ready  = 1'b0;
    psum_out_valid = 1'b0;
    psum_out_data  = '0;
    done           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_ok) begin
            state_d = StMac;
            base_d  = '0;
            j_d     = '0;
            acc_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StMac: begin
        acc_d = acc_q + PSUM_WIDTH'(prod);
        j_d   = j_q + 1'b1;
        if (last_tap) begin
          j_d     = '0;
          state_d = psum_en_q ? StPsum : StEmit;
        end
      end
      StPsum: begin
        psum_in_ready = 1'b1;
        if (psum_in_valid) begin
          acc_d   = acc_q + psum_in_data;
          state_d = StEmit;
        end
      end
      StEmit: begin
        psum_out_valid = 1'b1;
        psum_out_data  = acc_q;
        if (psum_out_ready) begin
          if (last_out) begin
            state_d = StDone;
          end else begin
            base_d  = base_q + stride_q;
            j_d     = '0;
            acc_d   = '0;
            state_d = StMac;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_conv1d_row_pe_sync.sv
// Bench for conv1d_row_pe_sync: directed and randomized jobs checked against a
// direct convolution model held in plain arrays.
module tb_conv1d_row_pe_sync;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned PSUM_WIDTH = 20;
  localparam int unsigned DEPTH_F    = 8;
  localparam int unsigned ADDR_F     = 3;
  localparam int unsigned DEPTH_I    = 16;
  localparam int unsigned ADDR_I     = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  filter_wr_en;
  logic [ADDR_F-1:0]     filter_wr_addr;
  logic [WIDTH-1:0]      filter_wr_data;
  logic                  ifmap_wr_en;
  logic [ADDR_I-1:0]     ifmap_wr_addr;
  logic [WIDTH-1:0]      ifmap_wr_data;
  logic [ADDR_F:0]       cfg_filt_len;
  logic [ADDR_I:0]       cfg_ifmap_len;
  logic [ADDR_I-1:0]     cfg_stride;
  logic                  cfg_psum_en;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;
  logic                  psum_in_valid;
  logic                  psum_in_ready;
  logic [PSUM_WIDTH-1:0] psum_in_data;
  logic                  psum_out_valid;
  logic                  psum_out_ready;
  logic [PSUM_WIDTH-1:0] psum_out_data;

  always #5 clk = ~clk;

  conv1d_row_pe_sync #(
    .WIDTH(WIDTH), .PSUM_WIDTH(PSUM_WIDTH), .DEPTH_F(DEPTH_F), .ADDR_F(ADDR_F),
    .DEPTH_I(DEPTH_I), .ADDR_I(ADDR_I)
  ) dut (
    .clk(clk), .reset(reset),
    .filter_wr_en(filter_wr_en), .filter_wr_addr(filter_wr_addr),
    .filter_wr_data(filter_wr_data),
    .ifmap_wr_en(ifmap_wr_en), .ifmap_wr_addr(ifmap_wr_addr), .ifmap_wr_data(ifmap_wr_data),
    .cfg_filt_len(cfg_filt_len), .cfg_ifmap_len(cfg_ifmap_len), .cfg_stride(cfg_stride),
    .cfg_psum_en(cfg_psum_en), .start(start), .busy(busy), .done(done), .cfg_err(cfg_err),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready),
    .psum_out_data(psum_out_data)
  );

  int checks   = 0;
  int failures = 0;

  // Reference contents of the PE's register files and the upstream psum stream
  int filt_m [DEPTH_F];
  int ifm_m  [DEPTH_I];
  int pin_m  [DEPTH_I];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // All tasks enter and leave at a falling edge
  task automatic wr_f(input int a, input int d);
    filter_wr_en   = 1'b1;
    filter_wr_addr = ADDR_F'(a);
    filter_wr_data = WIDTH'(d);
    filt_m[a]      = d & 255;
    @(negedge clk);
    filter_wr_en = 1'b0;
  endtask

  task automatic wr_i(input int a, input int d);
    ifmap_wr_en   = 1'b1;
    ifmap_wr_addr = ADDR_I'(a);
    ifmap_wr_data = WIDTH'(d);
    ifm_m[a]      = d & 255;
    @(negedge clk);
    ifmap_wr_en = 1'b0;
  endtask

  task automatic load_123_12345();
    for (int i = 0; i < 3; i++) wr_f(i, i + 1);
    for (int i = 0; i < 5; i++) wr_i(i, i + 1);
  endtask

  task automatic set_cfg(input int f, input int l, input int s, input bit pen);
    cfg_filt_len  = (ADDR_F + 1)'(f);
    cfg_ifmap_len = (ADDR_I + 1)'(l);
    cfg_stride    = ADDR_I'(s);
    cfg_psum_en   = pen;
  endtask

  // Run one job; junk=1 adds psum_in gaps plus dropped writes and ignored starts while busy
  task automatic run_job(input int f, input int l, input int s, input bit pen, input int stall,
                         input bit junk, input bit simwr, input int simwr_val, input string tag);
    int n, got, c, first_c, done_cnt, stall_cnt, in_k, stab_err, viol;
    int exp_a [DEPTH_I];
    longint sum;
    bit done_prev, finished;
    logic [PSUM_WIDTH-1:0] held;
    set_cfg(f, l, s, pen);
    start = 1'b1;
    if (simwr) begin
      filter_wr_en   = 1'b1;
      filter_wr_addr = '0;
      filter_wr_data = WIDTH'(simwr_val);
      filt_m[0]      = simwr_val & 255;
    end
    n = (l - f) / s + 1;
    for (int k = 0; k < n; k++) begin
      sum = 0;
      for (int j = 0; j < f; j++) sum += longint'(filt_m[j]) * longint'(ifm_m[k * s + j]);
      if (pen) sum += longint'(pin_m[k]);
      exp_a[k] = int'(sum % (longint'(1) << PSUM_WIDTH));
    end
    psum_out_ready = (stall == 0);
    psum_in_valid  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    filter_wr_en = 1'b0;
    got = 0; c = 0; first_c = -1; done_cnt = 0; stall_cnt = 0; in_k = 0;
    stab_err = 0; viol = 0; done_prev = 0; finished = 0; held = '0;
    chk({tag, " busy_after_start"}, busy, 1);
    while (!finished && c < 3000) begin
      if (done_prev) begin
        chk({tag, " busy_cleared"}, busy, 0);
        filter_wr_en = 1'b0; ifmap_wr_en = 1'b0; start = 1'b0; psum_in_valid = 1'b0;
        finished = 1;
      end else begin
        if (done) done_cnt++;
        done_prev = done;
        if (cfg_err) viol++;
        if (psum_in_ready && (!pen || psum_out_valid)) viol++;
        if (psum_in_ready) begin
          if (junk && $urandom_range(0, 2) == 0) psum_in_valid = 1'b0;
          else begin
            psum_in_valid = 1'b1;
            psum_in_data  = PSUM_WIDTH'(pin_m[in_k]);
            in_k++;
          end
        end else begin
          psum_in_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
          psum_in_data  = PSUM_WIDTH'($urandom);
        end
        if (junk) begin
          filter_wr_en   = 1'($urandom_range(0, 1));
          filter_wr_addr = ADDR_F'($urandom);
          filter_wr_data = WIDTH'($urandom);
          ifmap_wr_en    = 1'($urandom_range(0, 1));
          ifmap_wr_addr  = ADDR_I'($urandom);
          ifmap_wr_data  = WIDTH'($urandom);
          start          = 1'($urandom_range(0, 1));
          set_cfg($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)));
        end
        if (psum_out_valid) begin
          if (first_c < 0) first_c = c;
          if (stall_cnt < stall) begin
            if (stall_cnt > 0 && psum_out_data !== held) stab_err++;
            held = psum_out_data;
            stall_cnt++;
            psum_out_ready = 1'b0;
          end else begin
            if (stall > 0 && psum_out_data !== held) stab_err++;
            psum_out_ready = 1'b1;
            stall_cnt = 0;
            if (got < n) chk($sformatf("%s out%0d", tag, got), psum_out_data, exp_a[got]);
            got++;
          end
        end else begin
          psum_out_ready = (stall == 0);
        end
      end
      @(negedge clk);
      c++;
    end
    chk({tag, " finished_in_budget"}, finished, 1);
    chk({tag, " output_count"}, got, n);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " hold_stable"}, stab_err, 0);
    chk({tag, " handshake_rules"}, viol, 0);
    if (!pen) chk({tag, " first_valid_latency"}, first_c, f);
    psum_out_ready = 1'b0;
  endtask

  task automatic reject(input int f, input int l, input int s, input string tag);
    set_cfg(f, l, s, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " cfg_err"}, cfg_err, 1);
    chk({tag, " busy"}, busy, 0);
    @(negedge clk);
    chk({tag, " after"}, {cfg_err, busy, psum_out_valid}, 0);
  endtask

  initial begin
    reset = 1'b1;
    filter_wr_en = 0; filter_wr_addr = '0; filter_wr_data = '0;
    ifmap_wr_en = 0; ifmap_wr_addr = '0; ifmap_wr_data = '0;
    set_cfg(0, 0, 0, 0);
    start = 0; psum_in_valid = 0; psum_in_data = '0; psum_out_ready = 0;
    for (int i = 0; i < int'(DEPTH_F); i++) filt_m[i] = 0;
    for (int i = 0; i < int'(DEPTH_I); i++) begin ifm_m[i] = 0; pin_m[i] = 0; end
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, cfg_err, psum_in_ready, psum_out_valid},  0);
    chk("reset_data", psum_out_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // filter[0] lands together with the accepted start
    wr_f(1, 2); wr_f(2, 3);
    for (int i = 0; i < 5; i++) wr_i(i, i + 1);
    run_job(3, 5, 1, 0, 0, 0, 1, 1, "s1");
    run_job(3, 5, 2, 0, 0, 0, 0, 0, "s2");
    pin_m[0] = 100; pin_m[1] = 200; pin_m[2] = 300;
    run_job(3, 5, 1, 1, 0, 1, 0, 0, "psum");
    run_job(3, 5, 1, 0, 10, 0, 0, 0, "stall");

    reject(0, 5, 1, "rej_f0");
    reject(4, 3, 1, "rej_f_gt_l");
    reject(3, 5, 0, "rej_s0");
    reject(9, 16, 1, "rej_f_gt_depth");
    reject(3, 17, 1, "rej_l_gt_depth");

    for (int i = 0; i < 8; i++) begin wr_f(i, 255); wr_i(i, 255); end
    run_job(8, 8, 1, 0, 0, 0, 0, 0, "max");

    for (int t = 0; t < 6; t++) begin
      int f, l, s;
      for (int i = 0; i < int'(DEPTH_F); i++) wr_f(i, $urandom_range(0, 255));
      for (int i = 0; i < int'(DEPTH_I); i++) begin
        wr_i(i, $urandom_range(0, 255));
        pin_m[i] = $urandom_range(0, (1 << PSUM_WIDTH) - 1);
      end
      f = $urandom_range(1, 8);
      l = $urandom_range(f, 16);
      s = $urandom_range(1, 15);
      run_job(f, l, s, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1, 0, 0,
              $sformatf("rnd%0d", t));
    end

    // Reset while the second output is on offer
    load_123_12345();
    set_cfg(3, 5, 1, 0);
    psum_out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrst_second_valid", psum_out_valid, 1);
    chk("midrst_second_data", psum_out_data, 20);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {busy, done, cfg_err, psum_in_ready, psum_out_valid}, 0);
    chk("midrst_data", psum_out_data, 0);
    reset = 1'b0;
    for (int i = 0; i < int'(DEPTH_F); i++) filt_m[i] = 0;
    for (int i = 0; i < int'(DEPTH_I); i++) ifm_m[i] = 0;
    @(negedge clk);
    chk("midrst_no_done", done, 0);
    run_job(3, 5, 1, 0, 0, 0, 0, 0, "cleared");
    load_123_12345();
    run_job(3, 5, 1, 0, 0, 0, 0, 0, "reloaded");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
